// File: rtl/mmp_dac_pkg.sv
// Shared encodings and parameter sanity helpers for the multi-lane I2S/LJ DAC serializer.
`ifndef MMP_DAC_RANGE_OK
`define MMP_DAC_RANGE_OK(v, lo, hi) (((v) >= (lo)) && ((v) <= (hi)))
`endif

package mmp_dac_pkg;

  localparam logic MODE_LJ  = 1'b0;
  localparam logic MODE_I2S = 1'b1;

  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

  function automatic bit params_ok(input int num_dac, input int sample_w, input int slot_w,
                                   input int bclk_div, input int i2s_mode);
    return (num_dac >= 1) &&
           `MMP_DAC_RANGE_OK(sample_w, 8, 32) &&
           `MMP_DAC_RANGE_OK(slot_w, sample_w, 32) &&
           (bclk_div >= 1) &&
           `MMP_DAC_RANGE_OK(i2s_mode, 0, 1);
  endfunction

endpackage

// File: rtl/mmp_i2s_lane.sv
// One stereo data lane: holds the current frame's L/R samples and drives the serial bit
// selected by the slot and bit index supplied by the shared timing logic.
module mmp_i2s_lane
  import mmp_dac_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int BIT_W    = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                load,
  input  logic                slot_r,
  input  logic [BIT_W-1:0]    bit_k,
  input  logic [SAMPLE_W-1:0] hold_l,
  input  logic [SAMPLE_W-1:0] hold_r,
  output logic                sd
);

  logic [SAMPLE_W-1:0] sh_l_q, sh_l_d;
  logic [SAMPLE_W-1:0] sh_r_q, sh_r_d;
  logic [SAMPLE_W-1:0] cur_smpl;
  logic [SAMPLE_W-1:0] shifted;
  logic                sd_q, sd_d;

  always_comb begin
    sh_l_d   = sh_l_q;
    sh_r_d   = sh_r_q;
    if (load) begin
      sh_l_d = hold_l;
      sh_r_d = hold_r;
    end
    // The first bit of a new frame must come from the sample being loaded on that same tick.
    cur_smpl = (slot_r == WS_RIGHT) ? sh_r_d : sh_l_d;
    // Shifting past the sample width yields zero, which pads the unused tail of the slot.
    shifted  = cur_smpl << bit_k;
    sd_d     = sd_q;
    if (tick) begin
      sd_d = shifted[SAMPLE_W-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_l_q <= '0;
      sh_r_q <= '0;
      sd_q   <= 1'b0;
    end else begin
      sh_l_q <= sh_l_d;
      sh_r_q <= sh_r_d;
      sd_q   <= sd_d;
    end
  end

  assign sd = sd_q;

endmodule

// File: rtl/mmp_i2s_tx_multi.sv
// Multi-lane I2S / left-justified serializer: BCLK/WS generation, frame counter, double-buffered
// sample holding registers with request/underrun/overrun reporting, and one serializer per lane.
module mmp_i2s_tx_multi
  import mmp_dac_pkg::*;
#(
  parameter int NUM_DAC  = 2,
  parameter int SAMPLE_W = 16,
  parameter int SLOT_W   = 16,
  parameter int BCLK_DIV = 1,
  parameter int I2S_MODE = 1
) (
  input  logic                         i_CLK,
  input  logic                         i_RST_n,
  input  logic                         i_VALID,
  input  logic [NUM_DAC*SAMPLE_W-1:0]  i_SMPL_L,
  input  logic [NUM_DAC*SAMPLE_W-1:0]  i_SMPL_R,
  output logic                         o_REQ,
  output logic                         o_UNDERRUN,
  output logic                         o_OVERRUN,
  output logic                         o_DAC_CLK,
  output logic                         o_DAC_WS,
  output logic [NUM_DAC-1:0]           o_DAC_SD
);

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int HOLD_W  = NUM_DAC * SAMPLE_W;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] SLOT_IDX = BIT_W'(SLOT_W);

  if (!params_ok(NUM_DAC, SAMPLE_W, SLOT_W, BCLK_DIV, I2S_MODE)) begin : g_bad_params
    $error("mmp_i2s_tx_multi: parameter out of range");
  end

  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic              dac_clk_q, dac_clk_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              ws_q, ws_d;
  logic              req_q, req_d;
  logic              underrun_q, underrun_d;
  logic              overrun_q, overrun_d;
  logic              hold_full_q, hold_full_d;
  logic [HOLD_W-1:0] hold_l_q, hold_l_d;
  logic [HOLD_W-1:0] hold_r_q, hold_r_d;

  logic              div_wrap;
  logic              fall_tick;
  logic              frame_load;
  logic [BIT_W-1:0]  bit_nxt;
  logic [BIT_W-1:0]  ws_idx;
  logic              slot_r;
  logic [BIT_W-1:0]  bit_k;

  assign div_wrap   = (div_cnt_q == DIV_LAST);
  assign fall_tick  = div_wrap && dac_clk_q;
  assign frame_load = fall_tick && (bit_cnt_q == BIT_LAST);

  // Bit clock divider and frame position.
  always_comb begin
    div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
    dac_clk_d = div_wrap ? ~dac_clk_q : dac_clk_q;
    bit_cnt_d = bit_cnt_q;
    if (fall_tick) begin
      bit_cnt_d = frame_load ? '0 : bit_cnt_q + 1'b1;
    end
  end

  // In Philips mode WS looks one bit ahead so it flips during the last bit of the previous slot.
  always_comb begin
    bit_nxt = (bit_cnt_d == BIT_LAST) ? '0 : bit_cnt_d + 1'b1;
    ws_idx  = (I2S_MODE == int'(MODE_I2S)) ? bit_nxt : bit_cnt_d;
    ws_d    = ws_q;
    if (fall_tick) begin
      ws_d = (ws_idx >= SLOT_IDX) ? WS_RIGHT : WS_LEFT;
    end
    slot_r = (bit_cnt_d >= SLOT_IDX) ? WS_RIGHT : WS_LEFT;
    bit_k  = (slot_r == WS_RIGHT) ? bit_cnt_d - SLOT_IDX : bit_cnt_d;
  end

  // Sample handshake. A valid landing on the load cycle refills the buffer the load just drained.
  always_comb begin
    req_d       = frame_load;
    underrun_d  = frame_load && !hold_full_q;
    overrun_d   = overrun_q | (i_VALID && hold_full_q && !frame_load);
    hold_full_d = hold_full_q;
    if (frame_load) begin
      hold_full_d = 1'b0;
    end
    if (i_VALID) begin
      hold_full_d = 1'b1;
    end
    hold_l_d = i_VALID ? i_SMPL_L : hold_l_q;
    hold_r_d = i_VALID ? i_SMPL_R : hold_r_q;
  end

  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      div_cnt_q   <= '0;
      dac_clk_q   <= 1'b0;
      bit_cnt_q   <= '0;
      ws_q        <= WS_LEFT;
      req_q       <= 1'b0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      dac_clk_q   <= dac_clk_d;
      bit_cnt_q   <= bit_cnt_d;
      ws_q        <= ws_d;
      req_q       <= req_d;
      underrun_q  <= underrun_d;
      overrun_q   <= overrun_d;
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
    end
  end

  for (genvar n = 0; n < NUM_DAC; n++) begin : g_lane
    mmp_i2s_lane #(
      .SAMPLE_W (SAMPLE_W),
      .BIT_W    (BIT_W)
    ) u_lane (
      .clk    (i_CLK),
      .rst_n  (i_RST_n),
      .tick   (fall_tick),
      .load   (frame_load),
      .slot_r (slot_r),
      .bit_k  (bit_k),
      .hold_l (hold_l_q[n*SAMPLE_W +: SAMPLE_W]),
      .hold_r (hold_r_q[n*SAMPLE_W +: SAMPLE_W]),
      .sd     (o_DAC_SD[n])
    );
  end

  assign o_REQ      = req_q;
  assign o_UNDERRUN = underrun_q;
  assign o_OVERRUN  = overrun_q;
  assign o_DAC_CLK  = dac_clk_q;
  assign o_DAC_WS   = ws_q;

endmodule

// File: tb/tb_mmp_i2s_tx_multi.sv
// Directed bench for mmp_i2s_tx_multi: three parameter sets, frames captured on BCLK rise.
module tb_mmp_i2s_tx_multi;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_a_n, rst_b_n, rst_c_n;
  logic        vld;
  logic [31:0] smpl_l, smpl_r;

  logic       req_a, und_a, ovr_a, bclk_a, ws_a;
  logic [1:0] sd_a;
  logic       req_b, und_b, ovr_b, bclk_b, ws_b;
  logic [1:0] sd_b;
  logic       req_c, und_c, ovr_c, bclk_c, ws_c;
  logic [1:0] sd_c;

  mmp_i2s_tx_multi #(.NUM_DAC(2), .SAMPLE_W(16), .SLOT_W(16), .BCLK_DIV(1), .I2S_MODE(1)) u_dut_a (
    .i_CLK(clk), .i_RST_n(rst_a_n), .i_VALID(vld), .i_SMPL_L(smpl_l), .i_SMPL_R(smpl_r),
    .o_REQ(req_a), .o_UNDERRUN(und_a), .o_OVERRUN(ovr_a), .o_DAC_CLK(bclk_a), .o_DAC_WS(ws_a),
    .o_DAC_SD(sd_a));

  mmp_i2s_tx_multi #(.NUM_DAC(2), .SAMPLE_W(16), .SLOT_W(24), .BCLK_DIV(1), .I2S_MODE(0)) u_dut_b (
    .i_CLK(clk), .i_RST_n(rst_b_n), .i_VALID(vld), .i_SMPL_L(smpl_l), .i_SMPL_R(smpl_r),
    .o_REQ(req_b), .o_UNDERRUN(und_b), .o_OVERRUN(ovr_b), .o_DAC_CLK(bclk_b), .o_DAC_WS(ws_b),
    .o_DAC_SD(sd_b));

  mmp_i2s_tx_multi #(.NUM_DAC(2), .SAMPLE_W(16), .SLOT_W(16), .BCLK_DIV(3), .I2S_MODE(1)) u_dut_c (
    .i_CLK(clk), .i_RST_n(rst_c_n), .i_VALID(vld), .i_SMPL_L(smpl_l), .i_SMPL_R(smpl_r),
    .o_REQ(req_c), .o_UNDERRUN(und_c), .o_OVERRUN(ovr_c), .o_DAC_CLK(bclk_c), .o_DAC_WS(ws_c),
    .o_DAC_SD(sd_c));

  // Monitor mux: the capture task watches whichever DUT is selected.
  int         sel = 0;
  logic       mon_clk, mon_ws, mon_req, mon_und, mon_ovr;
  logic [1:0] mon_sd;
  always_comb begin
    case (sel)
      1:       {mon_clk, mon_ws, mon_req, mon_und, mon_ovr, mon_sd} = {bclk_b, ws_b, req_b, und_b, ovr_b, sd_b};
      2:       {mon_clk, mon_ws, mon_req, mon_und, mon_ovr, mon_sd} = {bclk_c, ws_c, req_c, und_c, ovr_c, sd_c};
      default: {mon_clk, mon_ws, mon_req, mon_und, mon_ovr, mon_sd} = {bclk_a, ws_a, req_a, und_a, ovr_a, sd_a};
    endcase
  end

  // ---------------- scoreboard / check ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Pulse i_VALID so that it is sampled on posedge number t.
  task automatic pulse(input int unsigned t, input logic [15:0] l0, input logic [15:0] r0,
                       input logic [15:0] l1, input logic [15:0] r1);
    while (cyc + 1 < t) @(negedge clk);
    vld    = 1'b1;
    smpl_l = {l1, l0};
    smpl_r = {r1, r0};
    @(negedge clk);
    vld    = 1'b0;
  endtask

  // Wait for o_REQ, then capture nbits serial bits on the following BCLK rising edges.
  task automatic grab(input int nbits, output int unsigned req_cyc, output logic und,
                      output logic pre_or, output logic [63:0] sd0, output logic [63:0] sd1,
                      output logic [63:0] ws, output int unsigned period, output int unsigned glitch);
    int          n;
    int          rises;
    int unsigned first_rise;
    logic        pclk, pws;
    logic [1:0]  psd;
    pre_or = 1'b0; sd0 = '0; sd1 = '0; ws = '0; period = 0; glitch = 0;
    req_cyc = 0; und = 1'b0; first_rise = 0; rises = 0; n = 0;
    while (!mon_req && n < 2000) begin
      pre_or |= |mon_sd;
      @(negedge clk);
      n++;
    end
    chk("req_seen", mon_req, 1'b1);
    if (!mon_req) return;
    req_cyc = cyc;
    und     = mon_und;
    pclk = mon_clk; pws = mon_ws; psd = mon_sd; n = 0;
    while (rises < nbits && n < 4000) begin
      @(negedge clk);
      n++;
      if ((mon_ws !== pws || mon_sd !== psd) && !(pclk && !mon_clk)) glitch++;
      if (mon_clk && !pclk) begin
        if (rises == 0) first_rise = cyc;
        else if (rises == 1) period = cyc - first_rise;
        sd0 = {sd0[62:0], mon_sd[0]};
        sd1 = {sd1[62:0], mon_sd[1]};
        ws  = {ws[62:0], mon_ws};
        rises++;
      end
      pclk = mon_clk; pws = mon_ws; psd = mon_sd;
    end
    chk("bits_seen", rises, nbits);
  endtask

  // ---------------- stimulus ----------------
  int unsigned rel, rq, rq_prev, per, gl;
  logic        und, pre;
  logic [63:0] s0, s1, w;

  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0; rst_c_n = 1'b0;
    vld = 1'b0; smpl_l = '0; smpl_r = '0;
    repeat (3) @(negedge clk);
    chk("rst_a_outs", {bclk_a, ws_a, sd_a, req_a, und_a, ovr_a}, 0);
    chk("rst_b_outs", {bclk_b, ws_b, sd_b, req_b, und_b, ovr_b}, 0);
    chk("rst_c_outs", {bclk_c, ws_c, sd_c, req_c, und_c, ovr_c}, 0);

    // DUT a: I2S 16/16, BCLK_DIV=1, frame = 64 cycles
    sel = 0;
    @(negedge clk);
    rst_a_n = 1'b1;
    rel = cyc;
    fork
      begin
        pulse(rel + 1,   16'h8001, 16'h7FFE, 16'h00FF, 16'hC3A5);
        pulse(rel + 200, 16'hABCD, 16'h0F0F, 16'h1357, 16'h2468);
        pulse(rel + 256, 16'h7777, 16'h8888, 16'h9ABC, 16'hDEF0);
        pulse(rel + 330, 16'h1111, 16'h2222, 16'h0000, 16'hFFFF);
        pulse(rel + 340, 16'h1234, 16'h5678, 16'h4321, 16'h8765);
      end
      begin
        grab(32, rq, und, pre, s0, s1, w, per, gl);
        chk("a_f1_req_delay", rq - rel, 64);
        chk("a_f1_zero_frame", pre, 0);
        chk("a_f1_underrun", und, 0);
        chk("a_f1_sd0", s0, 64'h8001_7FFE);
        chk("a_f1_sd1", s1, 64'h00FF_C3A5);
        chk("a_f1_ws", w, 64'h0001_FFFE);
        chk("a_f1_glitch", gl, 0);
        grab(32, rq, und, pre, s0, s1, w, per, gl);
        chk("a_f2_underrun", und, 1);
        chk("a_f2_sd0_repeat", s0, 64'h8001_7FFE);
        chk("a_f2_overrun", mon_ovr, 0);
        grab(32, rq, und, pre, s0, s1, w, per, gl);
        chk("a_f3_req_delay", rq - rel, 192);
        chk("a_f3_underrun", und, 1);
        chk("a_f3_sd1_repeat", s1, 64'h00FF_C3A5);
        grab(32, rq, und, pre, s0, s1, w, per, gl);
        chk("a_f4_underrun", und, 0);
        chk("a_f4_sd0_old", s0, 64'hABCD_0F0F);
        chk("a_f4_sd1_old", s1, 64'h1357_2468);
        chk("a_f4_overrun", mon_ovr, 0);
        grab(32, rq, und, pre, s0, s1, w, per, gl);
        chk("a_f5_underrun", und, 0);
        chk("a_f5_sd0_new", s0, 64'h7777_8888);
        grab(32, rq, und, pre, s0, s1, w, per, gl);
        chk("a_f6_underrun", und, 0);
        chk("a_f6_sd0_second", s0, 64'h1234_5678);
        chk("a_f6_sd1_second", s1, 64'h4321_8765);
        chk("a_f6_overrun", mon_ovr, 1);
      end
    join

    // Asynchronous reset in mid-slot, away from any clock edge
    repeat (7) @(negedge clk);
    #2;
    rst_a_n = 1'b0;
    #1;
    chk("a_async_rst", {bclk_a, ws_a, sd_a, req_a, und_a, ovr_a}, 0);
    repeat (2) @(negedge clk);
    rst_a_n = 1'b1;
    rel = cyc;
    grab(32, rq, und, pre, s0, s1, w, per, gl);
    chk("a_rr_req_delay", rq - rel, 64);
    chk("a_rr_zero_frame", pre, 0);
    chk("a_rr_underrun", und, 1);
    chk("a_rr_sd0", s0, 0);
    chk("a_rr_sd1", s1, 0);

    // DUT b: left-justified, SLOT_W=24, SAMPLE_W=16
    sel = 1;
    @(negedge clk);
    rst_b_n = 1'b1;
    rel = cyc;
    fork
      pulse(rel + 1, 16'hA5A5, 16'h5A5A, 16'h0001, 16'h8000);
      grab(48, rq, und, pre, s0, s1, w, per, gl);
    join
    chk("b_req_delay", rq - rel, 96);
    chk("b_underrun", und, 0);
    chk("b_sd0", s0, 64'hA5A500_5A5A00);
    chk("b_sd1", s1, 64'h000100_800000);
    chk("b_ws", w, 64'h000000_FFFFFF);
    chk("b_glitch", gl, 0);

    // DUT c: BCLK_DIV=3
    sel = 2;
    @(negedge clk);
    rst_c_n = 1'b1;
    rel = cyc;
    fork
      pulse(rel + 1, 16'hF00D, 16'h0123, 16'hCAFE, 16'hBEEF);
      grab(32, rq, und, pre, s0, s1, w, per, gl);
    join
    chk("c_req_delay", rq - rel, 192);
    chk("c_bclk_period", per, 6);
    chk("c_glitch", gl, 0);
    chk("c_sd0", s0, 64'hF00D_0123);
    chk("c_sd1", s1, 64'hCAFE_BEEF);
    chk("c_ws", w, 64'h0001_FFFE);
    chk("c_underrun", und, 0);
    rq_prev = rq;
    grab(32, rq, und, pre, s0, s1, w, per, gl);
    chk("c_req_interval", rq - rq_prev, 192);
    chk("c_f2_underrun", und, 1);
    chk("c_f2_glitch", gl, 0);
    chk("c_f2_sd0_repeat", s0, 64'hF00D_0123);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
